// File: rtl/filter_seq_ctrl.sv
// Sequences one in-place 5-tap filter pass over a BRAM: read, window shift, filter, write back.
// Optional build macro FILTER_SEQ_PAUSE_EN adds a pause input that stalls the read phase.
module filter_seq_ctrl #(
  parameter int N_SAMPLES = 1024,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef FILTER_SEQ_PAUSE_EN
  input  logic              pause,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_we,
  output logic [DATA_W-1:0] bram_wdata,
  input  logic [DATA_W-1:0] bram_rdata,
  output logic [DATA_W-1:0] tap0,
  output logic [DATA_W-1:0] tap1,
  output logic [DATA_W-1:0] tap2,
  output logic [DATA_W-1:0] tap3,
  output logic [DATA_W-1:0] tap4,
  output logic              filt_valid,
  input  logic [DATA_W-1:0] filt_result
);
  localparam int                TAPS     = 5;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_SAMPLES - 1);

  typedef enum logic [2:0] {IDLE, RD, WT, FL, WR, DN} state_t;

  state_t                      state, stateNxt;
  logic [ADDR_W-1:0]           idx;
  logic [TAPS-1:0][DATA_W-1:0] win;
  logic [DATA_W-1:0]           resReg;
  logic                        holdRd;

`ifdef FILTER_SEQ_PAUSE_EN
  assign holdRd = pause;
`else
  assign holdRd = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNxt;
  end

  // Outputs decode from state only, so async reset clears them in the same cycle.
  always_comb begin
    stateNxt   = state;
    busy       = 1'b0;
    done       = 1'b0;
    bram_we    = 1'b0;
    filt_valid = 1'b0;
    unique case (state)
      IDLE: if (start) stateNxt = RD;
      RD: begin
        busy = 1'b1;
        if (!holdRd) stateNxt = WT;
      end
      WT: begin
        busy     = 1'b1;
        stateNxt = FL;
      end
      FL: begin
        busy       = 1'b1;
        filt_valid = 1'b1;
        stateNxt   = WR;
      end
      WR: begin
        busy     = 1'b1;
        bram_we  = 1'b1;
        stateNxt = (idx == LAST_IDX) ? DN : RD;
      end
      DN: begin
        done     = 1'b1;
        stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  // Window is cleared at start so samples before index 0 read as zero padding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      win    <= '0;
      resReg <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          idx <= '0;
          win <= '0;
        end
        WT: win    <= {win[TAPS-2:0], bram_rdata};
        FL: resReg <= filt_result;
        WR: if (idx != LAST_IDX) idx <= idx + ADDR_W'(1);
        default: ;
      endcase
    end
  end

  assign bram_addr  = idx;
  assign bram_wdata = resReg;
  assign tap0       = win[0];
  assign tap1       = win[1];
  assign tap2       = win[2];
  assign tap3       = win[3];
  assign tap4       = win[4];

endmodule

// File: tb/tb_filter_seq_ctrl.sv
// Self-checking bench for filter_seq_ctrl: BRAM model, table vectors, random passes vs. array model.
module tb_filter_seq_ctrl;
  localparam int N  = 1024;
  localparam int AW = 10;
  localparam int DW = 8;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
`ifdef FILTER_SEQ_PAUSE_EN
  logic pause = 1'b0;
`endif
  logic          busy, done, bram_we, filt_valid;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_wdata, bram_rdata, filt_result;
  logic [DW-1:0] tap0, tap1, tap2, tap3, tap4;

  logic [DW-1:0] mem  [N];
  logic [DW-1:0] init [N];
  logic          doLoad = 1'b0;
  int            mode = 0;
  int            nChecks = 0, nFails = 0;
  int            expWr, fvCnt, doneCnt, lat;
  bit            track = 1'b0;

  typedef struct {
    int         mode;
    int         pat;
    int         addr;
    logic [7:0] exp;
  } vec_t;
  vec_t vt[10];

  always #5 clk = ~clk;

  filter_seq_ctrl #(.N_SAMPLES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef FILTER_SEQ_PAUSE_EN
    .pause(pause),
`endif
    .busy(busy), .done(done), .bram_addr(bram_addr), .bram_we(bram_we),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
    .tap0(tap0), .tap1(tap1), .tap2(tap2), .tap3(tap3), .tap4(tap4),
    .filt_valid(filt_valid), .filt_result(filt_result)
  );

  // Synchronous BRAM: read data one cycle after the address.
  always @(posedge clk) begin
    if (doLoad) begin
      for (int a = 0; a < N; a++) mem[a] <= init[a];
    end else begin
      if (bram_we) mem[bram_addr] <= bram_wdata;
      bram_rdata <= mem[bram_addr];
    end
  end

  function automatic logic [7:0] filtF(input int m, input logic [7:0] a, b, c, d, e);
    case (m)
      0:       return a;
      1:       return a + b + c + d + e;
      default: return (a ^ {b[6:0], 1'b0}) + (e >> 1) + c;
    endcase
  endfunction

  assign filt_result = filtF(mode, tap0, tap1, tap2, tap3, tap4);

  function automatic logic [7:0] origAt(input int j);
    return (j < 0) ? 8'h00 : init[j];
  endfunction

  // Each output uses only original samples: reads always run ahead of the in-place writes.
  function automatic logic [7:0] expOut(input int k);
    return filtF(mode, origAt(k), origAt(k-1), origAt(k-2), origAt(k-3), origAt(k-4));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      if (nFails <= 30) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (track) begin
      if (bram_we) begin
        chk("wr_addr", bram_addr, expWr);
        chk("wr_data", bram_wdata, expOut(expWr));
        chk("we_fv_excl", filt_valid, 0);
        chk("we_busy", busy, 1);
        expWr++;
      end
      if (filt_valid) begin
        chk("tap0", tap0, origAt(fvCnt));
        chk("tap1", tap1, origAt(fvCnt-1));
        chk("tap4", tap4, origAt(fvCnt-4));
        fvCnt++;
      end
      if (done) doneCnt++;
    end
  endtask

  task automatic load(input int pat);
    for (int a = 0; a < N; a++)
      case (pat)
        0:       init[a] = 8'(a % 256);
        1:       init[a] = 8'h10;
        default: init[a] = 8'($urandom_range(0, 255));
      endcase
    doLoad = 1'b1;
    step();
    doLoad = 1'b0;
  endtask

  task automatic chkMem(input int lim);
    for (int a = 0; a < N; a++)
      chk("mem", mem[a], (a < lim) ? expOut(a) : init[a]);
  endtask

  task automatic runPass(input int budget, input int startAgainAt, input bit randStart,
                         input int pauseAt, output int latency);
    expWr = 0; fvCnt = 0; doneCnt = 0; track = 1'b1;
    start = 1'b1;
    step();
    latency = 1;
    chk("busy_first_rd", busy, 1);
    while (!done && latency < budget) begin
      start = (latency - 1 == startAgainAt) || (randStart && $urandom_range(0, 15) == 0);
`ifdef FILTER_SEQ_PAUSE_EN
      pause = (pauseAt >= 0) && (latency - 1 >= pauseAt) && (latency - 1 < pauseAt + 10);
`else
      if (pauseAt >= 0) chk("pause_unsupported", 0, 1);
`endif
      step();
      latency++;
    end
    chk("done_seen", done, 1);
    chk("busy_in_dn", busy, 0);
    start = 1'b1;   // start during done must be ignored
    step();
    start = 1'b0;
    chk("start_on_done_ignored", busy, 0);
    repeat (3) step();
    chk("idle_after_pass", busy, 0);
    chk("done_count", doneCnt, 1);
    chk("filt_valid_count", fvCnt, N);
    chk("write_count", expWr, N);
    track = 1'b0;
  endtask

  initial begin
    vt[0] = '{0, 0, 0,    8'h00};
    vt[1] = '{0, 0, 300,  8'h2c};
    vt[2] = '{0, 0, 1023, 8'hff};
    vt[3] = '{1, 1, 0,    8'h10};
    vt[4] = '{1, 1, 1,    8'h20};
    vt[5] = '{1, 1, 2,    8'h30};
    vt[6] = '{1, 1, 3,    8'h40};
    vt[7] = '{1, 1, 4,    8'h50};
    vt[8] = '{1, 1, 500,  8'h50};
    vt[9] = '{1, 1, 1023, 8'h50};

    // Reset state
    repeat (2) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", bram_we, 0);
    chk("rst_fv", filt_valid, 0);
    chk("rst_addr", bram_addr, 0);
    chk("rst_wdata", bram_wdata, 0);
    chk("rst_taps", {tap0, tap1, tap2, tap3, tap4}, 0);
    rst_n = 1'b1;
    repeat (3) step();
    chk("idle_hold", busy, 0);

    // Table-driven passes: one pass per (mode, pattern) group
    for (int r = 0; r < 10; r++) begin
      if (r == 0 || vt[r].mode != vt[r-1].mode || vt[r].pat != vt[r-1].pat) begin
        mode = vt[r].mode;
        load(vt[r].pat);
        runPass(5000, -1, 1'b0, -1, lat);
        chk("pass_len", lat, 4 * N + 1);
        chkMem(N);
      end
      chk($sformatf("vec%0d", r), mem[vt[r].addr], vt[r].exp);
    end

    // Random data, nonlinear filter, start re-pulsed at cycle 100 plus random start noise
    mode = 2;
    load(2);
    runPass(5000, 100, 1'b1, -1, lat);
    chk("pass_len_rand", lat, 4 * N + 1);
    chkMem(N);

    // Reset at cycle 2000 of a pass (RD of sample 500)
    mode = 1;
    load(2);
    expWr = 0; fvCnt = 0; track = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (2000) step();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_we", bram_we, 0);
    chk("midrst_fv", filt_valid, 0);
    chk("midrst_addr", bram_addr, 0);
    repeat (3) step();
    chk("midrst_writes", expWr, 500);
    track = 1'b0;
    chkMem(500);

    // First start accepted on the first edge after reset release
    start = 1'b1;
    rst_n = 1'b1;
    step();
    start = 1'b0;
    chk("start_after_rst", busy, 1);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step();
    chk("rst_abort_idle", busy, 0);

`ifdef FILTER_SEQ_PAUSE_EN
    // Pause for 10 cycles at the RD of sample 7 (cycle 28)
    mode = 2;
    load(2);
    runPass(5000, -1, 1'b0, 28, lat);
    chk("pause_len", lat, 4 * N + 1 + 10);
    chkMem(N);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
